// File: rtl/rs_alu_station_pkg.sv
// rtl/rs_alu_station_pkg.sv - shared widths, opcodes and entry types for the ALU reservation station
package rs_alu_station_pkg;

    localparam int OPERATOR_WIDTH = 6;
    localparam int DATA_WIDTH     = 32;
    localparam int ADDRESS_WIDTH  = 32;
    localparam int ROB_WIDTH      = 4;
    localparam int RS_SIZE        = 16;
    localparam int RS_IDX_W       = 4;

    localparam logic [DATA_WIDTH-1:0]    ZERO_DATA = '0;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = '0;

    typedef enum logic [OPERATOR_WIDTH-1:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    typedef struct packed {
        logic                  enable;
        logic [ROB_WIDTH-1:0]  reorder;
        logic [DATA_WIDTH-1:0] result;
    } cdb_t;

    typedef struct packed {
        logic                     busy;
        op_e                      op;
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    imm;
        logic [ROB_WIDTH-1:0]     reorder;
        logic                     rs_ready;
        logic [DATA_WIDTH-1:0]    rs_value;
        logic [ROB_WIDTH-1:0]     rs_tag;
        logic                     rt_ready;
        logic [DATA_WIDTH-1:0]    rt_value;
        logic [ROB_WIDTH-1:0]     rt_tag;
    } rs_entry_t;

    // Returns {ready, value} after snooping both CDBs for a waiting operand.
    function automatic logic [DATA_WIDTH:0] capture(
        input logic                  ready,
        input logic [DATA_WIDTH-1:0] value,
        input logic [ROB_WIDTH-1:0]  tag,
        input cdb_t                  alu,
        input cdb_t                  lsb
    );
        if (ready)                                return {1'b1, value};
        if (alu.enable && (alu.reorder == tag))   return {1'b1, alu.result};
        if (lsb.enable && (lsb.reorder == tag))   return {1'b1, lsb.result};
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/rs_alu_station_if.sv
// rtl/rs_alu_station_if.sv - dispatch, CDB and ALU-issue bundle of the reservation station
interface rs_alu_station_if;
    import rs_alu_station_pkg::*;

    logic                     in_dispatch_enable;
    op_e                      in_dispatch_type;
    logic [ADDRESS_WIDTH-1:0] in_dispatch_pc;
    logic [DATA_WIDTH-1:0]    in_dispatch_imm;
    logic [ROB_WIDTH-1:0]     in_dispatch_reorder;
    logic                     in_dispatch_rs_ready;
    logic                     in_dispatch_rt_ready;
    logic [DATA_WIDTH-1:0]    in_dispatch_rs_value;
    logic [DATA_WIDTH-1:0]    in_dispatch_rt_value;
    logic [ROB_WIDTH-1:0]     in_dispatch_rs_tag;
    logic [ROB_WIDTH-1:0]     in_dispatch_rt_tag;

    logic                     in_alu_cdb_enable;
    logic [ROB_WIDTH-1:0]     in_alu_cdb_reorder;
    logic [DATA_WIDTH-1:0]    in_alu_cdb_result;
    logic                     in_lsb_cdb_enable;
    logic [ROB_WIDTH-1:0]     in_lsb_cdb_reorder;
    logic [DATA_WIDTH-1:0]    in_lsb_cdb_result;

    logic                     out_full;
    logic                     out_alu_enable;
    op_e                      out_alu_type;
    logic [ADDRESS_WIDTH-1:0] out_alu_pc;
    logic [DATA_WIDTH-1:0]    out_alu_imm;
    logic [DATA_WIDTH-1:0]    out_alu_rs;
    logic [DATA_WIDTH-1:0]    out_alu_rt;
    logic [ROB_WIDTH-1:0]     out_alu_reorder;

    modport master (
        output in_dispatch_enable, in_dispatch_type, in_dispatch_pc, in_dispatch_imm,
               in_dispatch_reorder, in_dispatch_rs_ready, in_dispatch_rt_ready,
               in_dispatch_rs_value, in_dispatch_rt_value, in_dispatch_rs_tag, in_dispatch_rt_tag,
               in_alu_cdb_enable, in_alu_cdb_reorder, in_alu_cdb_result,
               in_lsb_cdb_enable, in_lsb_cdb_reorder, in_lsb_cdb_result,
        input  out_full, out_alu_enable, out_alu_type, out_alu_pc, out_alu_imm,
               out_alu_rs, out_alu_rt, out_alu_reorder
    );

    modport slave (
        input  in_dispatch_enable, in_dispatch_type, in_dispatch_pc, in_dispatch_imm,
               in_dispatch_reorder, in_dispatch_rs_ready, in_dispatch_rt_ready,
               in_dispatch_rs_value, in_dispatch_rt_value, in_dispatch_rs_tag, in_dispatch_rt_tag,
               in_alu_cdb_enable, in_alu_cdb_reorder, in_alu_cdb_result,
               in_lsb_cdb_enable, in_lsb_cdb_reorder, in_lsb_cdb_result,
        output out_full, out_alu_enable, out_alu_type, out_alu_pc, out_alu_imm,
               out_alu_rs, out_alu_rt, out_alu_reorder
    );

endinterface

// File: rtl/rs_alu_station_select.sv
// rtl/rs_alu_station_select.sv - rs_select picker: lowest-index ready entry, or oldest ready entry under RS_AGE_ORDER_EN
module rs_select
    import rs_alu_station_pkg::*;
#(
    parameter int N  = RS_SIZE,
    parameter int IW = RS_IDX_W
) (
    input  logic [N-1:0]  ready,
`ifdef RS_AGE_ORDER_EN
    input  logic [IW:0]   age [N],
`endif
    output logic          found,
    output logic [IW-1:0] index
);

`ifdef RS_AGE_ORDER_EN
    logic [IW:0] best;

    // Largest relative age wins; ties fall to the lower index.
    always_comb begin
        found = 1'b0;
        index = '0;
        best  = '0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && (!found || (age[i] > best))) begin
                found = 1'b1;
                index = IW'(i);
                best  = age[i];
            end
        end
    end
`else
    // Priority encoder scanning down so the lowest ready index is left standing.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ready[i]) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/rs_alu_station.sv
// rtl/rs_alu_station.sv - ALU reservation station; RS_AGE_ORDER_EN selects oldest-first issue
module rs_alu_station
    import rs_alu_station_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              in_rob_clear,
    rs_alu_station_if.slave   bus
);

    rs_entry_t             ent   [RS_SIZE];
    rs_entry_t             woke  [RS_SIZE];
    rs_entry_t             new_ent;
    cdb_t                  alu_cdb;
    cdb_t                  lsb_cdb;
    logic [RS_SIZE-1:0]    busy_vec;
    logic [RS_SIZE-1:0]    ready_vec;
    logic                  sel_found;
    logic [RS_IDX_W-1:0]   sel_idx;
    logic [RS_IDX_W-1:0]   free_idx;
    logic                  accept;

    assign alu_cdb      = '{bus.in_alu_cdb_enable, bus.in_alu_cdb_reorder, bus.in_alu_cdb_result};
    assign lsb_cdb      = '{bus.in_lsb_cdb_enable, bus.in_lsb_cdb_reorder, bus.in_lsb_cdb_result};
    assign bus.out_full = &busy_vec;
    assign accept       = bus.in_dispatch_enable && !bus.out_full;

    // Occupancy and issue-eligibility vectors plus the snooped view of every entry.
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent[i].busy;
            ready_vec[i] = ent[i].busy && ent[i].rs_ready && ent[i].rt_ready;
            woke[i]      = ent[i];
            {woke[i].rs_ready, woke[i].rs_value} =
                capture(ent[i].rs_ready, ent[i].rs_value, ent[i].rs_tag, alu_cdb, lsb_cdb);
            {woke[i].rt_ready, woke[i].rt_value} =
                capture(ent[i].rt_ready, ent[i].rt_value, ent[i].rt_tag, alu_cdb, lsb_cdb);
        end
    end

    // Lowest free slot; only meaningful while out_full is low.
    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_vec[i]) free_idx = RS_IDX_W'(i);
        end
    end

    // Incoming entry with same-cycle CDB bypass on its operands.
    always_comb begin
        new_ent          = '0;
        new_ent.busy     = 1'b1;
        new_ent.op       = bus.in_dispatch_type;
        new_ent.pc       = bus.in_dispatch_pc;
        new_ent.imm      = bus.in_dispatch_imm;
        new_ent.reorder  = bus.in_dispatch_reorder;
        new_ent.rs_tag   = bus.in_dispatch_rs_tag;
        new_ent.rt_tag   = bus.in_dispatch_rt_tag;
        {new_ent.rs_ready, new_ent.rs_value} =
            capture(bus.in_dispatch_rs_ready, bus.in_dispatch_rs_value, bus.in_dispatch_rs_tag, alu_cdb, lsb_cdb);
        {new_ent.rt_ready, new_ent.rt_value} =
            capture(bus.in_dispatch_rt_ready, bus.in_dispatch_rt_value, bus.in_dispatch_rt_tag, alu_cdb, lsb_cdb);
    end

`ifdef RS_AGE_ORDER_EN
    logic [RS_IDX_W:0] age_cnt;
    logic [RS_IDX_W:0] stamp   [RS_SIZE];
    logic [RS_IDX_W:0] rel_age [RS_SIZE];

    // Distance back from the dispatch counter; larger means dispatched earlier.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) rel_age[i] = age_cnt - stamp[i];
    end

    // Dispatch counter and per-entry stamps; the counter restarts on a flush.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            age_cnt <= '0;
            for (int i = 0; i < RS_SIZE; i++) stamp[i] <= '0;
        end else if (in_rob_clear) begin
            age_cnt <= '0;
        end else if (rdy_in && accept) begin
            stamp[free_idx] <= age_cnt;
            age_cnt         <= age_cnt + 1'b1;
        end
    end
`endif

    rs_select #(.N(RS_SIZE), .IW(RS_IDX_W)) u_select (
        .ready (ready_vec),
`ifdef RS_AGE_ORDER_EN
        .age   (rel_age),
`endif
        .found (sel_found),
        .index (sel_idx)
    );

    // Entry storage and registered ALU issue port: snoop, issue, then dispatch.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
            bus.out_alu_enable  <= 1'b0;
            bus.out_alu_type    <= OP_LUI;
            bus.out_alu_pc      <= ZERO_ADDR;
            bus.out_alu_imm     <= ZERO_DATA;
            bus.out_alu_rs      <= ZERO_DATA;
            bus.out_alu_rt      <= ZERO_DATA;
            bus.out_alu_reorder <= '0;
        end else if (in_rob_clear) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
            bus.out_alu_enable <= 1'b0;
        end else if (!rdy_in) begin
            bus.out_alu_enable <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= woke[i];
            bus.out_alu_enable <= sel_found;
            if (sel_found) begin
                bus.out_alu_type    <= ent[sel_idx].op;
                bus.out_alu_pc      <= ent[sel_idx].pc;
                bus.out_alu_imm     <= ent[sel_idx].imm;
                bus.out_alu_rs      <= ent[sel_idx].rs_value;
                bus.out_alu_rt      <= ent[sel_idx].rt_value;
                bus.out_alu_reorder <= ent[sel_idx].reorder;
                ent[sel_idx].busy   <= 1'b0;
            end
            if (accept) ent[free_idx] <= new_ent;
        end
    end

endmodule

// File: tb/tb_rs_alu_station.sv
// tb/tb_rs_alu_station.sv - scoreboard bench for rs_alu_station with a slot-level reference model
module tb_rs_alu_station;
    import rs_alu_station_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    logic clr;
    rs_alu_station_if bus();

    rs_alu_station dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .rdy_in       (rdy),
        .in_rob_clear (clr),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        op_e         op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [3:0]  rob;
    } iss_t;

    typedef struct {
        bit          busy;
        op_e         op;
        logic [31:0] pc, imm;
        logic [3:0]  rob;
        bit          rs_rdy, rt_rdy;
        logic [31:0] rs_val, rt_val;
        logic [3:0]  rs_tag, rt_tag;
        int          seq;
    } slot_t;

    slot_t m [16];
    iss_t  expq [$];
    int    seq_ctr = 0;
    bit    exp_en  = 0;
    bit    run     = 0;
    int    total   = 0;
    int    bad     = 0;

    function automatic int occupancy();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m[i].busy) n++;
        return n;
    endfunction

    function automatic logic [32:0] snoop(bit r, logic [31:0] v, logic [3:0] t);
        if (r) return {1'b1, v};
        if (bus.in_alu_cdb_enable && bus.in_alu_cdb_reorder == t) return {1'b1, bus.in_alu_cdb_result};
        if (bus.in_lsb_cdb_enable && bus.in_lsb_cdb_reorder == t) return {1'b1, bus.in_lsb_cdb_result};
        return {1'b0, v};
    endfunction

    // Predict the effect of the coming edge from the current inputs.
    task automatic model_step();
        int sel  = -1;
        int free = -1;
        int occ  = occupancy();
        exp_en = 0;
        if (clr) begin
            for (int i = 0; i < 16; i++) m[i].busy = 0;
        end else if (rdy) begin
            for (int i = 0; i < 16; i++) begin
                if (m[i].busy && m[i].rs_rdy && m[i].rt_rdy) begin
`ifdef RS_AGE_ORDER_EN
                    if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
                    if (sel < 0) sel = i;
`endif
                end
                if (!m[i].busy && free < 0) free = i;
            end
            for (int i = 0; i < 16; i++) begin
                if (m[i].busy) begin
                    {m[i].rs_rdy, m[i].rs_val} = snoop(m[i].rs_rdy, m[i].rs_val, m[i].rs_tag);
                    {m[i].rt_rdy, m[i].rt_val} = snoop(m[i].rt_rdy, m[i].rt_val, m[i].rt_tag);
                end
            end
            if (sel >= 0) begin
                expq.push_back('{m[sel].op, m[sel].pc, m[sel].imm, m[sel].rs_val, m[sel].rt_val, m[sel].rob});
                m[sel].busy = 0;
                exp_en = 1;
            end
            if (bus.in_dispatch_enable && occ < 16) begin
                m[free].busy   = 1;
                m[free].op     = bus.in_dispatch_type;
                m[free].pc     = bus.in_dispatch_pc;
                m[free].imm    = bus.in_dispatch_imm;
                m[free].rob    = bus.in_dispatch_reorder;
                m[free].rs_tag = bus.in_dispatch_rs_tag;
                m[free].rt_tag = bus.in_dispatch_rt_tag;
                {m[free].rs_rdy, m[free].rs_val} = snoop(bus.in_dispatch_rs_ready, bus.in_dispatch_rs_value, bus.in_dispatch_rs_tag);
                {m[free].rt_rdy, m[free].rt_val} = snoop(bus.in_dispatch_rt_ready, bus.in_dispatch_rt_value, bus.in_dispatch_rt_tag);
                m[free].seq = seq_ctr++;
            end
        end
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic idle();
        rdy = 1; clr = 0;
        bus.in_dispatch_enable = 0;
        bus.in_dispatch_type = OP_LUI;
        bus.in_dispatch_pc = 0; bus.in_dispatch_imm = 0; bus.in_dispatch_reorder = 0;
        bus.in_dispatch_rs_ready = 1; bus.in_dispatch_rt_ready = 1;
        bus.in_dispatch_rs_value = 0; bus.in_dispatch_rt_value = 0;
        bus.in_dispatch_rs_tag = 0; bus.in_dispatch_rt_tag = 0;
        bus.in_alu_cdb_enable = 0; bus.in_alu_cdb_reorder = 0; bus.in_alu_cdb_result = 0;
        bus.in_lsb_cdb_enable = 0; bus.in_lsb_cdb_reorder = 0; bus.in_lsb_cdb_result = 0;
    endtask

    task automatic dispatch(op_e op, logic [31:0] pc, logic [31:0] imm, logic [3:0] rob,
                            bit rsr, logic [31:0] rsv, logic [3:0] rst,
                            bit rtr, logic [31:0] rtv, logic [3:0] rtt);
        bus.in_dispatch_enable = 1;
        bus.in_dispatch_type = op; bus.in_dispatch_pc = pc; bus.in_dispatch_imm = imm;
        bus.in_dispatch_reorder = rob;
        bus.in_dispatch_rs_ready = rsr; bus.in_dispatch_rs_value = rsv; bus.in_dispatch_rs_tag = rst;
        bus.in_dispatch_rt_ready = rtr; bus.in_dispatch_rt_value = rtv; bus.in_dispatch_rt_tag = rtt;
    endtask

    // One clock: model the edge, let it happen, check control outputs after it.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("alu_enable", 64'(bus.out_alu_enable), 64'(exp_en));
        check("full", 64'(bus.out_full), 64'(occupancy() == 16));
        idle();
    endtask

    // Scoreboard monitor: every presented issue must match the oldest prediction.
    always @(negedge clk) begin
        if (run && bus.out_alu_enable) begin
            iss_t act;
            iss_t req;
            act = '{bus.out_alu_type, bus.out_alu_pc, bus.out_alu_imm,
                    bus.out_alu_rs, bus.out_alu_rt, bus.out_alu_reorder};
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected: got %h expected none", act);
            end else begin
                req = expq.pop_front();
                if (act !== req) begin
                    bad++;
                    $display("FAIL issue_fields: got %h expected %h", act, req);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) m[i].busy = 0;
        rst_n = 0;
        idle();
        repeat (3) @(negedge clk);
        check("rst_enable",  64'(bus.out_alu_enable), 64'd0);
        check("rst_full",    64'(bus.out_full), 64'd0);
        check("rst_type",    64'(bus.out_alu_type), 64'd0);
        check("rst_pc",      64'(bus.out_alu_pc), 64'd0);
        check("rst_imm",     64'(bus.out_alu_imm), 64'd0);
        check("rst_rs",      64'(bus.out_alu_rs), 64'd0);
        check("rst_rt",      64'(bus.out_alu_rt), 64'd0);
        check("rst_reorder", 64'(bus.out_alu_reorder), 64'd0);
        rst_n = 1;
        run = 1;

        // ADDI with ready operand issues on the following edge.
        dispatch(OP_ADDI, 32'h100, 32'd3, 4'd2, 1, 32'd5, 4'd0, 1, 32'd0, 4'd0);
        tick();
        tick();
        tick();

        // ADD waiting on tag 4, woken by the ALU CDB two cycles later.
        dispatch(OP_ADD, 32'h104, 32'd0, 4'd3, 0, 32'd0, 4'd4, 1, 32'd1, 4'd0);
        tick();
        tick();
        tick();
        bus.in_alu_cdb_enable = 1; bus.in_alu_cdb_reorder = 4; bus.in_alu_cdb_result = 32'h10;
        tick();
        tick();

        // Dispatch-time bypass from the LSB CDB.
        dispatch(OP_SUB, 32'h108, 32'd0, 4'd5, 0, 32'd0, 4'd7, 1, 32'd2, 4'd0);
        bus.in_lsb_cdb_enable = 1; bus.in_lsb_cdb_reorder = 7; bus.in_lsb_cdb_result = 32'hAB;
        tick();
        tick();

        // Fill all slots with distinct waiting tags, then an ignored extra dispatch.
        for (int i = 0; i < 16; i++) begin
            dispatch(OP_XOR, 32'h200 + 32'(i * 4), 32'(i), 4'(i), 0, 32'd0, 4'(i), 1, 32'(i), 4'd0);
            tick();
        end
        check("full_after_fill", 64'(bus.out_full), 64'd1);
        dispatch(OP_OR, 32'hDEAD, 32'd9, 4'd15, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0);
        tick();
        bus.in_alu_cdb_enable = 1; bus.in_alu_cdb_reorder = 3; bus.in_alu_cdb_result = 32'h33;
        tick();
        tick();
        check("full_after_issue", 64'(bus.out_full), 64'd0);

        // Flush with entries waiting; stale tag afterwards must not wake anything.
        clr = 1;
        tick();
        check("flush_full", 64'(bus.out_full), 64'd0);
        bus.in_alu_cdb_enable = 1; bus.in_alu_cdb_reorder = 5; bus.in_alu_cdb_result = 32'h55;
        tick();
        tick();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            clr = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            if (occupancy() < 16 && $urandom_range(0, 1) == 1)
                dispatch(op_e'($urandom_range(0, 28)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2) != 0, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2) != 0, $urandom, 4'($urandom_range(0, 15)));
            bus.in_alu_cdb_enable  = $urandom_range(0, 1);
            bus.in_alu_cdb_reorder = 4'($urandom_range(0, 15));
            bus.in_alu_cdb_result  = $urandom;
            bus.in_lsb_cdb_enable  = $urandom_range(0, 1);
            bus.in_lsb_cdb_reorder = 4'($urandom_range(0, 15));
            bus.in_lsb_cdb_result  = $urandom;
            if (bus.in_alu_cdb_enable && bus.in_lsb_cdb_reorder == bus.in_alu_cdb_reorder)
                bus.in_lsb_cdb_enable = 0;
            tick();
        end

        check("queue_drained", 64'(expq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
